word_pair_buffer: RTL and testbench
===================================

# word_pair_buffer

Parametrised successor to the combinational word-pair setter. It accepts pairs of N-bit operand words through a valid/ready handshake and applies a per-transaction pair mode (pass, swap, clear second, duplicate first) at capture time. Pairs are held in a DEPTH-entry first-word-fall-through FIFO and presented downstream through a second valid/ready handshake. It sits between the operand-entry logic and the arithmetic blocks of the exercise datapath.

## Interface
Parameters:
- N, 4, bits per word
- DEPTH, 4, number of stored pairs; power of two, at least 2

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  producer offers a pair
- in_ready  out  1  buffer can accept a pair; equals count != DEPTH
- word_in1  in  N  first input word
- word_in2  in  N  second input word
- mode  in  2  pair mode, sampled with the pair: 00 pass, 01 swap, 10 clear word2, 11 duplicate word1
- flush  in  1  synchronous clear of contents
- out_valid  out  1  a pair is presented; equals count != 0
- out_ready  in  1  consumer accepts the presented pair
- word_out1  out  N  first word at head; all zeros when out_valid = 0
- word_out2  out  N  second word at head; all zeros when out_valid = 0
- count  out  clog2(DEPTH)+1  number of stored pairs

## Operation
- A push occurs when in_valid && in_ready. A pop occurs when out_valid && out_ready.
- On a push, the stored pair is a function of mode:
  - 00: (w1, w2)
  - 01: (w2, w1)
  - 10: (w1, 0)
  - 11: (w1, w1)
- Mode is not stored; only the transformed pair is stored.
- Storage:
  - DEPTH-entry array with write and read pointers of clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count is held in a separate register.
- Push without pop: write at wr_ptr, wr_ptr+1, count+1.
- Pop without push: rd_ptr+1, count-1.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
  - Legal only when 0 < count < DEPTH.
  - At count = DEPTH, in_ready = 0, so no push occurs. There is no combinational ready pass-through.
  - At count = 0, out_valid = 0, so no pop occurs. A pair pushed into an empty buffer is not bypassed.
- in_ready depends only on registered state. There is no combinational path from out_ready to in_ready.
- flush: on the next edge, pointers and count go to 0 and any push or pop in that cycle is discarded. flush has priority over the handshakes.
- Data held while out_valid = 1 && out_ready = 0 stays stable until popped.

## Timing
- Reset values: count 0, pointers 0, in_ready 1, out_valid 0, word_out1/word_out2 0. Array contents are don't-care.
- Reset mid-operation: all stored pairs are lost immediately, asynchronously. Outputs reach their reset values without a clock edge.
- Latency: a pair pushed at edge t is presented with out_valid = 1 after edge t, i.e. one cycle of latency.
- Throughput: one pair per cycle in steady state when 0 < count < DEPTH.
- Outputs are a combinational read of the head entry, masked by out_valid. count, in_ready and out_valid are registered-state decodes.

## Structure
- Shared include file holds the mode encodings (MODE_PASS, MODE_SWAP, MODE_CLR2, MODE_DUP1) and a clog2 constant function. The operand-entry blocks use the same file.
- Sub-module pair_mode_mux: combinational N-bit (w1, w2, mode) -> (p1, p2).
  - Generated per bit, in the same per-bit style as the existing setter.
  - Instantiated once, on the write side.
- Top level contains the storage array, pointers, count and handshake logic. The target is roughly 150–250 lines.

## Test plan
- Reset, then push (A, 5) with mode 00 while out_ready = 0.
  - Required: out_valid rises one cycle later with words (A, 5); count = 1.
- Push (3, C) with modes 01, 10 and 11 in consecutive cycles, then drain.
  - Required: pops (C, 3), (3, 0), (3, 3) in that order.
- With DEPTH = 4, fill with four pairs while holding out_ready = 0.
  - Required: in_ready = 0 and count = 4; a fifth in_valid is ignored.
  - After one pop, in_ready = 1.
- Hold push and pop continuously for 10 cycles at count = 2.
  - Required: count stays at 2; output order matches input order across pointer wrap.
- Assert flush together with in_valid and out_ready at count = 3.
  - Required: next cycle count = 0, out_valid = 0, outputs 0.
- Assert reset asynchronously mid-stream at count = 2.
  - Required: out_valid = 0 and count = 0 before the next clock edge.
  - Afterwards, the first pushed pair is presented correctly.

Source files
------------

// File: rtl/word_pair_buffer_pkg.sv
// Shared definitions for the word-pair datapath blocks:
// pair mode encodings and a constant clog2 helper.
package word_pair_buffer_pkg;

   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_SWAP = 2'b01;
   localparam logic [1:0] MODE_CLR2 = 2'b10;
   localparam logic [1:0] MODE_DUP1 = 2'b11;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/pair_mode_mux.sv
// Per-bit pair transform applied to a word pair.
// Ports: w1/w2 in words, mode in, p1/p2 transformed words out.
module pair_mode_mux
   import word_pair_buffer_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] w1,
   input  logic [N-1:0] w2,
   input  logic [1:0]   mode,
   output logic [N-1:0] p1,
   output logic [N-1:0] p2
);

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign p1[i] = (mode == MODE_SWAP) ? w2[i] : w1[i];
      assign p2[i] = (mode == MODE_PASS) ? w2[i] :
                     (mode == MODE_CLR2) ? 1'b0  : w1[i];
   end

endmodule

// File: rtl/word_pair_buffer.sv
// First-word-fall-through FIFO of transformed word pairs.
// Ports: clk, reset; in_valid/in_ready, word_in1/2, mode (push side);
//   out_valid/out_ready, word_out1/2 (pop side); flush; count.
module word_pair_buffer
   import word_pair_buffer_pkg::*;
#(
   parameter int N     = 4,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N-1:0]          word_in1,
   input  logic [N-1:0]          word_in2,
   input  logic [1:0]            mode,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N-1:0]          word_out1,
   output logic [N-1:0]          word_out2,
   output logic [clog2(DEPTH):0] count
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [N-1:0]  mem1_q [DEPTH];
   logic [N-1:0]  mem2_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [N-1:0]  p1, p2;
   logic          push, pop;

   pair_mode_mux #(.N(N)) u_mux (
      .w1   (word_in1),
      .w2   (word_in2),
      .mode (mode),
      .p1   (p1),
      .p2   (p2)
   );

   // Handshake flags decode registered count only.
   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = count_q;

   assign word_out1 = out_valid ? mem1_q[rd_ptr_q] : '0;
   assign word_out2 = out_valid ? mem2_q[rd_ptr_q] : '0;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; entries are only visible once counted.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem1_q[wr_ptr_q] <= p1;
         mem2_q[wr_ptr_q] <= p2;
      end
   end

endmodule

// File: tb/tb_word_pair_buffer.sv
// Directed self-checking bench for word_pair_buffer
// (N = 4, DEPTH = 4).
module tb_word_pair_buffer;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] word_in1;
   logic [3:0] word_in2;
   logic [1:0] mode;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] word_out1;
   logic [3:0] word_out2;
   logic [2:0] count;

   int n_checks;
   int n_fail;

   logic [7:0] q[$];
   logic [7:0] head;

   word_pair_buffer #(.N(4), .DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .word_in1  (word_in1),
      .word_in2  (word_in2),
      .mode      (mode),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .word_out1 (word_out1),
      .word_out2 (word_out2),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [3:0] a,
                        input logic [3:0] b,
                        input logic [1:0] m);
      in_valid = 1'b1;
      word_in1 = a;
      word_in2 = b;
      mode     = m;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      word_in1  = '0;
      word_in2  = '0;
      mode      = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #2;
      check("rst_count", 32'(count), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out1", 32'(word_out1), 0);
      check("rst_out2", 32'(word_out2), 0);
      reset = 1'b0;

      // single push, one-cycle latency
      offer(4'hA, 4'h5, 2'b00);
      step();
      in_valid = 1'b0;
      check("t1_valid", 32'(out_valid), 1);
      check("t1_out1", 32'(word_out1), 32'hA);
      check("t1_out2", 32'(word_out2), 32'h5);
      check("t1_count", 32'(count), 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("t1_empty", 32'(count), 0);

      // modes swap, clr2, dup1
      offer(4'h3, 4'hC, 2'b01);
      step();
      mode = 2'b10;
      step();
      mode = 2'b11;
      step();
      in_valid = 1'b0;
      check("t2_count", 32'(count), 3);
      out_ready = 1'b1;
      check("t2_swap", 32'({word_out1, word_out2}), 32'hC3);
      step();
      check("t2_clr2", 32'({word_out1, word_out2}), 32'h30);
      step();
      check("t2_dup1", 32'({word_out1, word_out2}), 32'h33);
      step();
      out_ready = 1'b0;
      check("t2_empty", 32'(out_valid), 0);

      // fill to DEPTH
      for (int i = 1; i <= 4; i++) begin
         offer(4'(i), 4'(i + 8), 2'b00);
         step();
      end
      check("t3_in_ready", 32'(in_ready), 0);
      check("t3_count", 32'(count), 4);
      offer(4'hF, 4'hF, 2'b00);
      step();
      check("t3_ignored", 32'(count), 4);
      check("t3_head", 32'({word_out1, word_out2}), 32'h19);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("t3_ready_back", 32'(in_ready), 1);
      check("t3_count3", 32'(count), 3);
      check("t3_head2", 32'({word_out1, word_out2}), 32'h2A);
      step();
      check("t4_count2", 32'(count), 2);

      // steady push+pop across pointer wrap
      q.delete();
      q.push_back(8'h3B);
      q.push_back(8'h4C);
      for (int k = 0; k < 10; k++) begin
         offer(4'(k + 5), ~4'(k + 5), 2'b00);
         head = q.pop_front();
         check("t4_head", 32'({word_out1, word_out2}), 32'(head));
         q.push_back({4'(k + 5), ~4'(k + 5)});
         step();
         check("t4_count", 32'(count), 2);
      end
      check("t4_final", 32'({word_out1, word_out2}), 32'(q[0]));

      // flush beats push and pop at count 3
      out_ready = 1'b0;
      offer(4'h7, 4'h1, 2'b00);
      step();
      check("t5_count3", 32'(count), 3);
      flush     = 1'b1;
      out_ready = 1'b1;
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("t5_count", 32'(count), 0);
      check("t5_valid", 32'(out_valid), 0);
      check("t5_outs", 32'({word_out1, word_out2}), 0);

      // async reset mid-stream at count 2
      offer(4'h1, 4'h2, 2'b00);
      step();
      offer(4'h3, 4'h4, 2'b00);
      step();
      in_valid = 1'b0;
      check("t6_count2", 32'(count), 2);
      #3;
      reset = 1'b1;
      #1;
      check("t6_valid", 32'(out_valid), 0);
      check("t6_count", 32'(count), 0);
      check("t6_outs", 32'({word_out1, word_out2}), 0);
      check("t6_in_ready", 32'(in_ready), 1);
      #1;
      reset = 1'b0;
      step();
      offer(4'h6, 4'h9, 2'b11);
      step();
      in_valid = 1'b0;
      check("t6_head", 32'({word_out1, word_out2}), 32'h66);
      check("t6_count1", 32'(count), 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
